matrix_sel_stream: RTL and testbench
====================================

Name: matrix_sel_stream

Overview:
Parametrised successor to the 4x4 two-source matrix select register in the FastICA datapath. Registers one NxN signed matrix chosen from NSRC sources, with load, symmetrise, transpose and hold modes. Adds a row-serial valid/ready readout that freezes the matrix while it streams, so downstream row-wise units (decorrelation, norm) can consume a stable matrix.

Parameters:
DW, 26, element width (signed two's complement)
N, 4, matrix dimension (N>=2)
NSRC, 2, number of source matrices (NSRC>=2)
SW, max(1,$clog2(NSRC)), source select width (derived localparam)
RW, max(1,$clog2(N)), row index width (derived localparam)

Ports:
clk_msel  in  1  clock, all state on rising edge
rst_msel  in  1  reset, synchronous, active-high
en_msel  in  1  0: track source 0 (legacy pass behaviour); 1: execute mode
mode  in  2  00 LOAD, 01 SYMM, 10 TRANSPOSE, 11 HOLD
sel  in  SW  source index
src_flat  in  NSRC*N*N*DW  element (r,c) of source s at [((s*N+r)*N+c)*DW +: DW]
mat_flat  out  N*N*DW  registered matrix, element (r,c) at [(r*N+c)*DW +: DW]
mat_valid  out  1  matrix written at least once since reset
rd_start  in  1  request row stream
rd_row  out  N*DW  current row, column c at [c*DW +: DW]
rd_idx  out  RW  current row index
rd_valid  out  1  rd_row valid
rd_ready  in  1  consumer accepts row
rd_last  out  1  rd_valid and rd_idx==N-1
busy  out  1  stream in progress, matrix frozen
ld_err  out  1  one-cycle pulse: rejected write request

Behaviour:
- Priority per edge: reset > freeze (busy) > en_msel/mode.
- Reset: mat all 0, mat_valid 0, FSM IDLE, rd_idx 0, rd_valid 0, rd_last 0, busy 0, ld_err 0; rd_row reads 0. Reset mid-stream aborts the stream; all of the above hold after that edge.
- Update latency 1 cycle; mat_valid set on any update.
- en_msel=0, !busy: mat <= source 0 every cycle.
- en_msel=1, !busy, sel<NSRC, A = source[sel]:
  LOAD: mat(r,c) <= A(r,c).
  SYMM: mat(r,c) <= (A(r,c)+A(c,r)) >>> 1, sum at DW+1 bits; arithmetic shift (floor); no overflow possible; diagonal = A(r,r) exactly.
  TRANSPOSE: mat(r,c) <= A(c,r).
  HOLD: no change, no error.
- en_msel=1, mode!=HOLD, sel>=NSRC: no update, mat_valid unchanged, ld_err=1 next cycle.
- busy=1: no update. en_msel=1 with mode!=HOLD gives ld_err=1 next cycle. en_msel=0 holds silently.
- FSM IDLE/STREAM, busy = (state==STREAM).
  IDLE: rd_start && mat_valid -> STREAM, rd_idx 0. rd_start with !mat_valid is ignored.
  rd_start in the same cycle as an accepted update: both take effect; the stream carries the new matrix.
  STREAM: rd_valid=1, rd_row = mat row rd_idx. rd_row and rd_idx stay stable while rd_valid && !rd_ready.
  Handshake (rd_valid && rd_ready): rd_idx+1. On the rd_last handshake: -> IDLE, busy=0 and rd_valid=0 next cycle, rd_idx=0.
  rd_start while busy is ignored, including in the final-handshake cycle; it is accepted one cycle later.
- IDLE: rd_valid=0, rd_last=0, rd_row = row 0 of mat (don't-care to consumers).

Test Plan:
- Reset: rst_msel high 2 cycles with random inputs -> mat_flat=0, mat_valid=0, rd_valid=0, busy=0, ld_err=0.
- Pass/LOAD (N=4, DW=26, NSRC=2): en=0, src0(0,1)=5 -> next cycle mat(0,1)=5, mat_valid=1. Then en=1 LOAD sel=1 with src1 all -3 -> mat all -3. sel=2 (SW=1 wraps to 0, so use NSRC=3 build): sel=3 -> ld_err pulse, mat unchanged.
- SYMM: A(0,1)=7, A(1,0)=-2 -> mat(0,1)=mat(1,0)=2. A(2,3)=-3, A(3,2)=0 -> -2. A(1,2)=A(2,1)=2^25-1 -> 2^25-1. A(3,3)=-9 -> -9.
- TRANSPOSE: A(r,c)=16r+c -> mat(r,c)=16c+r.
- Stream: rd_start, rd_ready sequence 1,0,0,1,1 -> rows 0,1,1,1,2 presented, then row 3 with rd_last. Row 1 bits are stable over its hold cycles. busy falls the cycle after the row-3 handshake.
- Freeze/abort: LOAD during STREAM -> mat unchanged, single ld_err pulse. rd_start in the final-handshake cycle is ignored. Reset asserted at rd_idx=2 -> rd_valid=0, busy=0, rd_idx=0 next cycle.

Source files
------------

// File: rtl/matrix_sel_stream.sv
// matrix_sel_stream
//
// Registers one NxN signed matrix picked from NSRC source matrices. Besides
// loading a source, it can load the symmetrised source, (A + A^T) / 2 with
// floor rounding, or the transposed source. A row-serial valid/ready readout
// streams the stored matrix one row per handshake. While a stream is in
// progress the matrix is frozen, so downstream row-wise units see stable data.
//
// Ports:
//   clk_msel   clock; all state changes on the rising edge
//   rst_msel   synchronous active-high reset
//   en_msel    0: track source 0 every cycle; 1: execute mode
//   mode       00 LOAD, 01 SYMM, 10 TRANSPOSE, 11 HOLD
//   sel        source index (values >= NSRC are rejected)
//   src_flat   element (r,c) of source s at [((s*N+r)*N+c)*DW +: DW]
//   mat_flat   stored matrix, element (r,c) at [(r*N+c)*DW +: DW]
//   mat_valid  matrix written at least once since reset
//   rd_start   request a row stream
//   rd_row     current row, column c at [c*DW +: DW]
//   rd_idx     current row index
//   rd_valid   rd_row valid
//   rd_ready   consumer accepts the current row
//   rd_last    rd_valid on the final row
//   busy       stream in progress, matrix frozen
//   ld_err     one-cycle pulse after a rejected write request
module matrix_sel_stream #(
    parameter int unsigned DW   = 26,
    parameter int unsigned N    = 4,
    parameter int unsigned NSRC = 2,
    localparam int unsigned SW  = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int unsigned RW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_msel,
    input  logic                   rst_msel,
    input  logic                   en_msel,
    input  logic [1:0]             mode,
    input  logic [SW-1:0]          sel,
    input  logic [NSRC*N*N*DW-1:0] src_flat,
    output logic [N*N*DW-1:0]      mat_flat,
    output logic                   mat_valid,
    input  logic                   rd_start,
    output logic [N*DW-1:0]        rd_row,
    output logic [RW-1:0]          rd_idx,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic                   busy,
    output logic                   ld_err
);

    typedef logic signed [DW-1:0] elem_t;

    typedef enum logic [1:0] {
        ModeLoad      = 2'b00,
        ModeSymm      = 2'b01,
        ModeTranspose = 2'b10,
        ModeHold      = 2'b11
    } mode_e;

    typedef enum logic {
        StIdle,
        StStream
    } state_e;

    localparam logic [RW-1:0] LastIdx = RW'(N - 1);

    // Floor of the mean of two elements. The sum is formed one bit wider so it
    // cannot overflow; dropping its LSB is an arithmetic shift right by one.
    function automatic elem_t symm_avg(input elem_t x, input elem_t y);
        logic [DW:0] s;
        s = {x[DW-1], x} + {y[DW-1], y};
        return elem_t'(s[DW:1]);
    endfunction

    elem_t  mat_q [N][N];
    elem_t  mat_d [N][N];
    elem_t  src0  [N][N];
    elem_t  src_a [N][N];
    logic   mat_valid_q, mat_valid_d;
    logic   err_q, err_d;
    logic   sel_ok;
    state_e state_q, state_d;
    logic [RW-1:0] idx_q, idx_d;

    // Unpack source 0 and the selected source
    always_comb begin
        sel_ok = (int'(sel) < int'(NSRC));
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                src0[r][c]  = src_flat[(r*N+c)*DW +: DW];
                src_a[r][c] = '0;
                for (int s = 0; s < NSRC; s++) begin
                    if (int'(sel) == s) begin
                        src_a[r][c] = src_flat[((s*N+r)*N+c)*DW +: DW];
                    end
                end
            end
        end
    end

    // Matrix update: a running stream freezes the matrix, then en_msel/mode
    always_comb begin
        mat_d       = mat_q;
        mat_valid_d = mat_valid_q;
        err_d       = 1'b0;
        if (state_q == StStream) begin
            // Writes are refused while streaming; only explicit requests flag it
            err_d = en_msel && (mode_e'(mode) != ModeHold);
        end else if (!en_msel) begin
            mat_d       = src0;
            mat_valid_d = 1'b1;
        end else if (mode_e'(mode) != ModeHold) begin
            if (!sel_ok) begin
                err_d = 1'b1;
            end else begin
                mat_valid_d = 1'b1;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        unique case (mode_e'(mode))
                            ModeLoad:      mat_d[r][c] = src_a[r][c];
                            ModeSymm:      mat_d[r][c] = symm_avg(src_a[r][c], src_a[c][r]);
                            ModeTranspose: mat_d[r][c] = src_a[c][r];
                            default:       mat_d[r][c] = mat_q[r][c];
                        endcase
                    end
                end
            end
        end
    end

    // Stream FSM next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                // Needs a matrix to stream; a same-cycle update lands first
                if (rd_start && mat_valid_q) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (rd_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_msel) begin
        if (rst_msel) begin
            mat_q       <= '{default: '0};
            mat_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= StIdle;
            idx_q       <= '0;
        end else begin
            mat_q       <= mat_d;
            mat_valid_q <= mat_valid_d;
            err_q       <= err_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
        end
    end

    // Outputs; in IDLE idx_q is 0 so rd_row shows row 0
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mat_flat[(r*N+c)*DW +: DW] = mat_q[r][c];
            end
        end
        for (int c = 0; c < N; c++) begin
            rd_row[c*DW +: DW] = mat_q[idx_q][c];
        end
    end

    assign mat_valid = mat_valid_q;
    assign rd_idx    = idx_q;
    assign busy      = (state_q == StStream);
    assign rd_valid  = busy;
    assign rd_last   = busy && (idx_q == LastIdx);
    assign ld_err    = err_q;

endmodule

// File: tb/tb_matrix_sel_stream.sv
// Directed bench for matrix_sel_stream (DW=26, N=4, NSRC=3 so that sel=3 is
// an out-of-range source). Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_matrix_sel_stream;

    localparam int unsigned DW   = 26;
    localparam int unsigned N    = 4;
    localparam int unsigned NSRC = 3;
    localparam int unsigned SW   = 2;
    localparam int unsigned RW   = 2;

    logic                   clk_msel;
    logic                   rst_msel;
    logic                   en_msel;
    logic [1:0]             mode;
    logic [SW-1:0]          sel;
    logic [NSRC*N*N*DW-1:0] src_flat;
    logic [N*N*DW-1:0]      mat_flat;
    logic                   mat_valid;
    logic                   rd_start;
    logic [N*DW-1:0]        rd_row;
    logic [RW-1:0]          rd_idx;
    logic                   rd_valid;
    logic                   rd_ready;
    logic                   rd_last;
    logic                   busy;
    logic                   ld_err;

    int n_vec = 0;
    int n_err = 0;

    matrix_sel_stream #(
        .DW   (DW),
        .N    (N),
        .NSRC (NSRC)
    ) dut (
        .clk_msel  (clk_msel),
        .rst_msel  (rst_msel),
        .en_msel   (en_msel),
        .mode      (mode),
        .sel       (sel),
        .src_flat  (src_flat),
        .mat_flat  (mat_flat),
        .mat_valid (mat_valid),
        .rd_start  (rd_start),
        .rd_row    (rd_row),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .busy      (busy),
        .ld_err    (ld_err)
    );

    initial clk_msel = 1'b0;
    always #5 clk_msel = ~clk_msel;

    initial begin
        #200000;
        $display("FAIL timeout: run did not end, got %0d vectors expected fewer", n_vec);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_msel);
        #1;
    endtask

    task automatic set_src(input int s, input int r, input int c, input int v);
        src_flat[((s*N+r)*N+c)*DW +: DW] = DW'(v);
    endtask

    function automatic logic signed [DW-1:0] mat_el(input int r, input int c);
        return mat_flat[(r*N+c)*DW +: DW];
    endfunction

    function automatic logic signed [DW-1:0] row_el(input int c);
        return rd_row[c*DW +: DW];
    endfunction

    int ready_seq [5] = '{1, 0, 0, 1, 1};
    int row_seq   [5] = '{0, 1, 1, 1, 2};

    initial begin
        // Reset with arbitrary inputs
        rst_msel = 1'b1;
        en_msel  = 1'($urandom);
        mode     = 2'($urandom);
        sel      = 2'($urandom);
        src_flat = '0;
        for (int i = 0; i < NSRC*N*N; i++) src_flat[i*DW +: DW] = DW'($urandom);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        tick();
        check_val("rst_mat_zero", 64'(|mat_flat), 0);
        check_val("rst_mat_valid", mat_valid, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ld_err", ld_err, 0);
        check_val("rst_rd_idx", rd_idx, 0);

        // Stream request before any matrix is written is ignored
        rst_msel = 1'b0;
        en_msel  = 1'b1;
        mode     = 2'b11;
        sel      = 0;
        src_flat = '0;
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        check_val("start_no_matrix_busy", busy, 0);
        check_val("hold_no_valid", mat_valid, 0);
        rd_start = 1'b0;

        // Pass-through of source 0
        set_src(0, 0, 1, 5);
        en_msel = 1'b0;
        tick();
        check_val("pass_m01", mat_el(0, 1), 5);
        check_val("pass_valid", mat_valid, 1);

        // LOAD source 1, all -3
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) set_src(1, r, c, -3);
        en_msel = 1'b1;
        mode    = 2'b00;
        sel     = 1;
        tick();
        check_val("load_m00", mat_el(0, 0), -3);
        check_val("load_m01", mat_el(0, 1), -3);
        check_val("load_m32", mat_el(3, 2), -3);

        // Out-of-range source: rejected, single-cycle error
        sel = 3;
        tick();
        check_val("badsel_err", ld_err, 1);
        check_val("badsel_m01", mat_el(0, 1), -3);
        mode = 2'b11;
        tick();
        check_val("badsel_err_pulse", ld_err, 0);

        // SYMM from source 2
        set_src(2, 0, 1, 7);
        set_src(2, 1, 0, -2);
        set_src(2, 2, 3, -3);
        set_src(2, 3, 2, 0);
        set_src(2, 1, 2, (1 << 25) - 1);
        set_src(2, 2, 1, (1 << 25) - 1);
        set_src(2, 3, 3, -9);
        mode = 2'b01;
        sel  = 2;
        tick();
        check_val("symm_m01", mat_el(0, 1), 2);
        check_val("symm_m10", mat_el(1, 0), 2);
        check_val("symm_m23", mat_el(2, 3), -2);
        check_val("symm_m32", mat_el(3, 2), -2);
        check_val("symm_m12_max", mat_el(1, 2), (1 << 25) - 1);
        check_val("symm_m21_max", mat_el(2, 1), (1 << 25) - 1);
        check_val("symm_m33", mat_el(3, 3), -9);
        check_val("symm_m00", mat_el(0, 0), 0);

        // TRANSPOSE of A(r,c) = 16r+c from source 1
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) set_src(1, r, c, 16*r + c);
        mode = 2'b10;
        sel  = 1;
        tick();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check_val($sformatf("trn_m%0d%0d", r, c), mat_el(r, c), 16*c + r);
        mode = 2'b11;

        // Stream with rd_ready pattern 1,0,0,1,1; row r col c = 16c+r
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("strm%0d_valid", k), rd_valid, 1);
            check_val($sformatf("strm%0d_busy", k), busy, 1);
            check_val($sformatf("strm%0d_idx", k), rd_idx, row_seq[k]);
            check_val($sformatf("strm%0d_last", k), rd_last, 0);
            for (int c = 0; c < N; c++)
                check_val($sformatf("strm%0d_c%0d", k, c), row_el(c), 16*c + row_seq[k]);
            if (k == 2) begin
                check_val("frz_err", ld_err, 1);
                check_val("frz_m01", mat_el(0, 1), 16);
            end
            if (k == 3) check_val("frz_err_pulse", ld_err, 0);
            // LOAD attempt while streaming, on row 1's first hold cycle
            mode     = (k == 1) ? 2'b00 : 2'b11;
            sel      = 0;
            rd_ready = ready_seq[k][0];
            tick();
        end
        check_val("last_idx", rd_idx, 3);
        check_val("last_flag", rd_last, 1);
        for (int c = 0; c < N; c++)
            check_val($sformatf("last_c%0d", c), row_el(c), 16*c + 3);

        // Final handshake with rd_start: ignored this cycle
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        check_val("end_busy", busy, 0);
        check_val("end_valid", rd_valid, 0);
        check_val("end_last", rd_last, 0);
        check_val("end_idx", rd_idx, 0);

        // Same request one cycle later is accepted
        rd_ready = 1'b0;
        tick();
        check_val("restart_busy", busy, 1);
        check_val("restart_idx", rd_idx, 0);
        rd_start = 1'b0;

        // Advance to row 2, then reset aborts the stream
        rd_ready = 1'b1;
        tick();
        tick();
        check_val("abort_pre_idx", rd_idx, 2);
        rst_msel = 1'b1;
        rd_ready = 1'b0;
        tick();
        check_val("abort_valid", rd_valid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_idx", rd_idx, 0);
        check_val("abort_mat_valid", mat_valid, 0);
        check_val("abort_mat_zero", 64'(|mat_flat), 0);
        rst_msel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
